// File: rtl/mips_fetch_stage_pkg.sv
// Shared MIPS definitions used by the fetch stage and the decode stage.
// Holds the instruction/ROM geometry, the NOP encoding and the IF/ID register layout.
package mips_fetch_stage_pkg;

    localparam int Instruction_Width          = 32;
    localparam int Instruction_Mem_Addr_Width = 6;
    localparam int Instruction_Mem_Depth      = 1 << Instruction_Mem_Addr_Width;
    localparam int PC_Width_Default           = 32;

    localparam logic [Instruction_Width-1:0] MIPS_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [Instruction_Width-1:0] instr;
        logic [PC_Width_Default-1:0]  pc;
        logic [PC_Width_Default-1:0]  pc_plus4;
        logic                         valid;
    } if_id_t;

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM port, IF/ID register out.
interface mips_fetch_stage_if #(
    parameter int PC_Width = 32
);
    logic                                                    stall;
    logic                                                    redirect_valid;
    logic [PC_Width-1:0]                                     redirect_pc;
    logic [mips_fetch_stage_pkg::Instruction_Mem_Addr_Width-1:0] rom_addr;
    logic [mips_fetch_stage_pkg::Instruction_Width-1:0]      rom_data;
    logic [mips_fetch_stage_pkg::Instruction_Width-1:0]      if_id_instr;
    logic [PC_Width-1:0]                                     if_id_pc;
    logic [PC_Width-1:0]                                     if_id_pc_plus4;
    logic                                                    if_id_valid;
    logic                                                    misaligned_err;

    modport master (
        input  stall, redirect_valid, redirect_pc, rom_data,
        output rom_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, misaligned_err
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, rom_data,
        input  rom_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, misaligned_err
    );
endinterface

// File: rtl/mips_pc_reg.sv
// Program counter with redirect > stall > advance priority and sticky misalignment flag.
// Latency: PC updates on the rising edge; pc_plus4 is combinational from the PC.
// Backpressure: stall holds the PC; a redirect always wins over stall.
module mips_pc_reg #(
    parameter int                  PC_Width = 32,
    parameter logic [PC_Width-1:0] Reset_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_Width-1:0] redirect_pc,
    output logic [PC_Width-1:0] pc,
    output logic [PC_Width-1:0] pc_plus4,
    output logic                misaligned_err
);

    // Wraps modulo 2^PC_Width by construction.
    assign pc_plus4 = pc + PC_Width'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= Reset_PC;
            misaligned_err <= 1'b0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[PC_Width-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_err <= 1'b1;
            end
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch: drives ROM word address, captures instr/PC/PC+4 into IF/ID.
// Latency: 1 cycle from PC presentation to IF/ID; a redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; redirect flushes IF/ID even when stalled.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter int                  PC_Width = 32,
    parameter logic [PC_Width-1:0] Reset_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_fetch_stage_if.master bus
);

    logic [PC_Width-1:0] pc;
    logic [PC_Width-1:0] pc_plus4;
    if_id_t              if_id_q;

    mips_pc_reg #(
        .PC_Width (PC_Width),
        .Reset_PC (Reset_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misaligned_err (bus.misaligned_err)
    );

    // Upper PC bits are dropped, so fetch wraps modulo the ROM depth.
    assign bus.rom_addr = pc[Instruction_Mem_Addr_Width+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.instr    <= MIPS_NOP;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Flush: wrong-path fetch is dropped, PC fields keep their old values.
            if_id_q.instr <= MIPS_NOP;
            if_id_q.valid <= 1'b0;
        end else if (!bus.stall) begin
            if_id_q.instr    <= bus.rom_data;
            if_id_q.pc       <= pc;
            if_id_q.pc_plus4 <= pc_plus4;
            if_id_q.valid    <= 1'b1;
        end
    end

    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc       = if_id_q.pc;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage; ROM word i holds 32'hC0DE_0000 + i.
module tb_mips_fetch_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] rom [0:63];

    mips_fetch_stage_if #(.PC_Width(32)) bus ();

    mips_fetch_stage #(
        .PC_Width (32),
        .Reset_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic valid, input logic [5:0] addr);
        check({tag, ".instr"}, bus.if_id_instr, instr);
        check({tag, ".pc"}, bus.if_id_pc, pc);
        check({tag, ".pc4"}, bus.if_id_pc_plus4, pc4);
        check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(valid));
        check({tag, ".addr"}, 32'(bus.rom_addr), 32'(addr));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 6'd0);
        check("reset.err", 32'(bus.misaligned_err), 32'h0);
        #1 rst_n = 1'b1;

        // Free run: A, B
        edge_step(); check_ifid("run_a", 32'hC0DE_0000, 32'h0, 32'h4, 1'b1, 6'd1);
        edge_step(); check_ifid("run_b", 32'hC0DE_0001, 32'h4, 32'h8, 1'b1, 6'd2);

        // Stall three cycles holding B
        bus.stall = 1'b1;
        edge_step(); check_ifid("stall1", 32'hC0DE_0001, 32'h4, 32'h8, 1'b1, 6'd2);
        edge_step(); check_ifid("stall2", 32'hC0DE_0001, 32'h4, 32'h8, 1'b1, 6'd2);
        edge_step(); check_ifid("stall3", 32'hC0DE_0001, 32'h4, 32'h8, 1'b1, 6'd2);
        bus.stall = 1'b0;
        edge_step(); check_ifid("run_c", 32'hC0DE_0002, 32'h8, 32'hC, 1'b1, 6'd3);
        edge_step(); check_ifid("run_d", 32'hC0DE_0003, 32'hC, 32'h10, 1'b1, 6'd4);

        // Redirect to 0x20: one bubble then word 8
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20;
        edge_step(); check_ifid("redir_bubble", 32'h0, 32'hC, 32'h10, 1'b0, 6'd8);
        bus.redirect_valid = 1'b0;
        edge_step(); check_ifid("redir_tgt", 32'hC0DE_0008, 32'h20, 32'h24, 1'b1, 6'd9);

        // Redirect overrides simultaneous stall
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; bus.stall = 1'b1;
        edge_step(); check_ifid("redir_stall", 32'h0, 32'h20, 32'h24, 1'b0, 6'd16);
        bus.redirect_valid = 1'b0;
        edge_step(); check_ifid("hold_bubble", 32'h0, 32'h20, 32'h24, 1'b0, 6'd16);
        bus.stall = 1'b0;
        edge_step(); check_ifid("after_stall", 32'hC0DE_0010, 32'h40, 32'h44, 1'b1, 6'd17);

        // Misaligned target, then back-to-back aligned redirect
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h22;
        edge_step(); check_ifid("misal", 32'h0, 32'h40, 32'h44, 1'b0, 6'd8);
        check("misal.err", 32'(bus.misaligned_err), 32'h1);
        bus.redirect_pc = 32'h50;
        edge_step(); check_ifid("b2b", 32'h0, 32'h40, 32'h44, 1'b0, 6'd20);
        check("b2b.err", 32'(bus.misaligned_err), 32'h1);
        bus.redirect_valid = 1'b0;
        edge_step(); check_ifid("b2b_tgt", 32'hC0DE_0014, 32'h50, 32'h54, 1'b1, 6'd21);
        check("sticky.err", 32'(bus.misaligned_err), 32'h1);

        // Last ROM word, address wraps to 0
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFC;
        edge_step(); check("last.addr", 32'(bus.rom_addr), 32'd63);
        bus.redirect_valid = 1'b0;
        edge_step(); check_ifid("last_word", 32'hC0DE_003F, 32'hFC, 32'h100, 1'b1, 6'd0);
        edge_step(); check_ifid("wrapped", 32'hC0DE_0000, 32'h100, 32'h104, 1'b1, 6'd1);

        // PC arithmetic wraps at 2^32
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        edge_step(); check("top.addr", 32'(bus.rom_addr), 32'd63);
        bus.redirect_valid = 1'b0;
        edge_step(); check_ifid("pc_wrap", 32'hC0DE_003F, 32'hFFFF_FFFC, 32'h0, 1'b1, 6'd0);

        // Asynchronous reset mid-stream, no clock edge needed
        #2 rst_n = 1'b0;
        #1;
        check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 6'd0);
        check("async_rst.err", 32'(bus.misaligned_err), 32'h0);
        #2 rst_n = 1'b1;
        edge_step(); check_ifid("rerun_a", 32'hC0DE_0000, 32'h0, 32'h4, 1'b1, 6'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
